// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//
// Purpose:
//   Shares one external, pipelined 8-bit adder between two requesters.
//   A combinational round-robin arbiter grants at most one requester per
//   cycle, drives the adder operands and clock enable, and tracks each issued
//   operation through a tag pipeline whose depth matches the adder latency.
//   When the tag reaches the last stage the adder sum is registered and
//   returned to the requester that issued it as a one-cycle pulse.
//
// Parameters:
//   ADD_LATENCY  cycles (of add_ce) from operand capture to a valid add_s;
//                legal range 1..4.
//
// Ports:
//   clock                  single rising-edge clock
//   rst_n                  asynchronous active-low reset
//   enable                 permits new grants; in-flight work always drains
//   req0_valid, req1_valid requester has an operand pair pending
//   req0_a/b, req1_a/b     8-bit requester operands
//   req0_ready, req1_ready grant (handshake = valid & ready)
//   add_a, add_b           operands to the shared adder (0 when idle)
//   add_ce                 clock enable to the shared adder
//   add_s                  9-bit sum from the shared adder
//   resp0_valid/resp1_valid one-cycle result pulse per requester
//   resp_sum               9-bit result, valid while a resp*_valid is high
//   busy                   an operation is in flight or a response is out
//   done0_cnt, done1_cnt   16-bit completed-operation counters (wrapping)
// -----------------------------------------------------------------------------
module adder_arbiter #(
    parameter int ADD_LATENCY = 1
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_ce,
    input  logic [8:0]  add_s,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [8:0]  resp_sum,
    output logic        busy,
    output logic [15:0] done0_cnt,
    output logic [15:0] done1_cnt
);

    // Round-robin pointer: id of the most recently granted requester.
    logic                   r_last;

    // Tag pipeline, one bit of valid and one bit of id per adder stage.
    logic [ADD_LATENCY-1:0] r_tag_vld;
    logic [ADD_LATENCY-1:0] r_tag_id;

    logic                   r_resp0_valid;
    logic                   r_resp1_valid;
    logic [8:0]             r_resp_sum;
    logic [15:0]            r_done0;
    logic [15:0]            r_done1;

    logic                   w_hs0;
    logic                   w_hs1;
    logic                   w_hs;
    logic                   w_gnt_id;
    logic                   w_inflight;
    logic                   w_ce;
    logic                   w_fin;
    logic [ADD_LATENCY-1:0] w_vld_next;
    logic [ADD_LATENCY-1:0] w_id_next;

    // Grants are qualified with rst_n so that every output reads 0 while
    // reset is held, even though the grant path is purely combinational.
    // On contention the requester that did not win last time is granted.
    assign w_hs0    = rst_n & enable & req0_valid & (~req1_valid | r_last);
    assign w_hs1    = rst_n & enable & req1_valid & (~req0_valid | ~r_last);
    assign w_hs     = w_hs0 | w_hs1;
    assign w_gnt_id = w_hs1;

    assign w_inflight = |r_tag_vld;
    // The adder only advances when there is something to push through it,
    // so every in-flight operation sees exactly ADD_LATENCY enabled edges.
    assign w_ce       = w_hs | w_inflight;
    assign w_fin      = r_tag_vld[ADD_LATENCY-1];

    generate
        if (ADD_LATENCY == 1) begin : g_tag_single
            assign w_vld_next = w_hs;
            assign w_id_next  = w_gnt_id;
        end else begin : g_tag_multi
            assign w_vld_next = {r_tag_vld[ADD_LATENCY-2:0], w_hs};
            assign w_id_next  = {r_tag_id[ADD_LATENCY-2:0], w_gnt_id};
        end
    endgenerate

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_last        <= 1'b1;   // requester 0 wins the first contention
            r_tag_vld     <= '0;
            r_tag_id      <= '0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp_sum    <= '0;
            r_done0       <= '0;
            r_done1       <= '0;
        end else begin
            if (w_hs) begin
                r_last <= w_gnt_id;
            end

            // ---- issue -> adder stages (tags move in step with add_ce) ----
            if (w_ce) begin
                r_tag_vld <= w_vld_next;
                r_tag_id  <= w_id_next;
            end

            // ---- last adder stage -> response register ----
            r_resp0_valid <= w_ce & w_fin & ~r_tag_id[ADD_LATENCY-1];
            r_resp1_valid <= w_ce & w_fin &  r_tag_id[ADD_LATENCY-1];

            if (w_ce && w_fin) begin
                r_resp_sum <= add_s;
                // Counters change on the same edge that raises the pulse,
                // so they already include the response while it is visible.
                if (r_tag_id[ADD_LATENCY-1]) begin
                    r_done1 <= r_done1 + 16'd1;
                end else begin
                    r_done0 <= r_done0 + 16'd1;
                end
            end
        end
    end

    assign req0_ready  = w_hs0;
    assign req1_ready  = w_hs1;
    assign add_a       = w_hs0 ? req0_a : (w_hs1 ? req1_a : 8'd0);
    assign add_b       = w_hs0 ? req0_b : (w_hs1 ? req1_b : 8'd0);
    assign add_ce      = w_ce;
    assign resp0_valid = r_resp0_valid;
    assign resp1_valid = r_resp1_valid;
    assign resp_sum    = r_resp_sum;
    // Stays high through the response pulse, drops the cycle after.
    assign busy        = w_inflight | r_resp0_valid | r_resp1_valid;
    assign done0_cnt   = r_done0;
    assign done1_cnt   = r_done1;

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter ADD_LATENCY, default 1: clock cycles from operand capture by the shared adder to a valid result on add_s; legal range 1..4.
REQ-002 clock  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 enable  input  1  high permits new grants; low blocks new grants while in-flight operations drain.
REQ-005 req0_valid, req1_valid  input  1 each  requester has an operand pair pending.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  8 each  requester operands.
REQ-007 req0_ready, req1_ready  output  1 each  grant; a handshake occurs when valid and ready are both high in the same cycle.
REQ-008 add_a, add_b  output  8 each  operands to the shared adder.
REQ-009 add_ce  output  1  clock enable to the shared adder.
REQ-010 add_s  input  9  shared adder sum.
REQ-011 resp0_valid, resp1_valid  output  1 each  one-cycle result pulse per requester.
REQ-012 resp_sum  output  9  result shared by both responses; valid only while a resp*_valid is high.
REQ-013 busy  output  1  high while any operation is in flight or a response is pending.
REQ-014 done0_cnt, done1_cnt  output  16 each  completed-operation counters per requester; wrap modulo 2^16.

Function
REQ-015 Arbitration shall be combinational in the current cycle: at most one ready high, and only when enable=1 and that requester's valid=1.
REQ-016 With exactly one valid requester, that requester shall be granted.
REQ-017 With both valid, the requester not granted most recently shall be granted (1-bit round-robin pointer, updated on every handshake).
REQ-018 add_a/add_b shall be driven from the granted requester's operands in the handshake cycle; when there is no handshake they shall be 0.
REQ-019 add_ce shall be high in any cycle with a handshake or with at least one operation in flight, and low otherwise.
REQ-020 A tag pipeline of ADD_LATENCY stages shall advance only when add_ce=1; each stage holds {valid, requester id}, and stage 0 loads {handshake, granted id}.
REQ-021 When the final tag stage is valid and add_ce=1, add_s shall be registered into resp_sum, and the matching resp*_valid shall pulse for exactly one cycle.
REQ-022 Latency shall be fixed: resp*_valid is high in cycle k+ADD_LATENCY+1 for a handshake in cycle k.
REQ-023 Throughput shall be one handshake per cycle; back-to-back issues shall return results in issue order with no loss.
REQ-024 Responses have no backpressure; the requester shall accept every response pulse.
REQ-025 The resp_sum width rule: 9-bit unsigned sum, with bit 8 as the carry; no saturation.
REQ-026 When enable goes low mid-stream, grants shall stop the same cycle, in-flight operations shall complete normally, and busy shall fall the cycle after the last response.
REQ-027 done0_cnt/done1_cnt shall increment on their resp*_valid pulse; 0xFFFF shall wrap to 0x0000.
REQ-028 A requester shall hold its valid and operands stable until its handshake; a drop before the handshake is legal and cancels the request.

Reset
REQ-029 While rst_n=0, all outputs shall be 0: ready, add_a/add_b, add_ce, resp*_valid, resp_sum, busy, and both counters.
REQ-030 Reset shall clear all tag stages and set the round-robin pointer so that requester 0 wins the first contention.
REQ-031 Reset mid-operation shall discard in-flight operations; no response shall be produced for them after release.
REQ-032 The first grant shall be possible in the first cycle after rst_n deasserts.

Verification (ADD_LATENCY=1 unless stated)
REQ-033 Single request: req0 {a=0x12, b=0x34} at cycle k -> req0_ready=1 at k; resp0_valid=1 and resp_sum=0x046 at k+2; done0_cnt=1.
REQ-034 Contention: both valid for 4 cycles, req0 {0xFF,0x01}, req1 {0x80,0x80} -> grant order 0,1,0,1; responses 0x100, 0x100 alternating, ids matching; each counter ends at 2.
REQ-035 Latency sweep: ADD_LATENCY=3 with a 5-cycle back-to-back stream from req1 -> responses in cycles k+4..k+8, in order; add_ce falls the cycle after the last in-flight result.
REQ-036 Drain: enable dropped one cycle after two issues -> no further ready; both responses arrive; busy clears the cycle after the second pulse.
REQ-037 Reset mid-flight: rst_n pulsed low the cycle after an issue -> no resp pulse; all outputs 0; the next contention grants req0.
REQ-038 Counter wrap: done0_cnt preloaded by running 65536 req0 ops -> done0_cnt reads 0x0000; done1_cnt unchanged.
